ready_valid_serializer: RTL and testbench



---
 rtl/ready_valid_serializer.sv | 140 ++++++++++++++
 tb/tb_ready_valid_serializer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ready_valid_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ready_valid_serializer                                     |
// | Description : Transmit-side width converter for a ready/valid stream.   |
// |               Accepts one IN_WIDTH word per upstream handshake and       |
// |               emits it as IN_WIDTH/OUT_WIDTH beats of OUT_WIDTH bits,    |
// |               marking the final beat with out_last. Sustains one beat    |
// |               per cycle across word boundaries.                          |
// | Option      : READY_VALID_SERIALIZER_MSB_FIRST_EN - when defined, beats  |
// |               leave most-significant first; otherwise LSB first.         |
// | Ports       : clk       - single clock, rising edge                      |
// |               reset     - asynchronous, active-high                      |
// |               in_valid  - upstream word valid                            |
// |               in_data   - upstream word [IN_WIDTH-1:0]                   |
// |               in_ready  - word can be accepted this cycle (comb.)        |
// |               out_valid - beat valid (registered)                        |
// |               out_data  - current beat [OUT_WIDTH-1:0] (registered)      |
// |               out_last  - final beat of the word (registered)            |
// |               out_ready - downstream accepts the beat                    |
// | Note        : IN_WIDTH must be an integer multiple of OUT_WIDTH.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ready_valid_serializer #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last,
   input  logic                 out_ready
);

   localparam int               BEATS    = IN_WIDTH / OUT_WIDTH;
   localparam int               CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(BEATS - 1);
   localparam logic             C_SINGLE = (BEATS == 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IN_WIDTH-1:0] shreg_q, shreg_d;
   logic                out_last_q, out_last_d;

   logic [IN_WIDTH-1:0] w_shreg_shift;
   logic                w_in_fire;
   logic                w_out_fire;

   // Word register advanced by one beat toward its output end. A single-beat
   // word never shifts, so that build has nothing to move.
   generate
      if (BEATS > 1) begin : g_multi_beat
`ifdef READY_VALID_SERIALIZER_MSB_FIRST_EN
         assign w_shreg_shift = {shreg_q[IN_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
`else
         assign w_shreg_shift = {{OUT_WIDTH{1'b0}}, shreg_q[IN_WIDTH-1:OUT_WIDTH]};
`endif
      end else begin : g_single_beat
         assign w_shreg_shift = '0;
      end
   endgenerate

   assign out_valid  = (state_q == S_SEND);
   assign out_last   = out_last_q;
`ifdef READY_VALID_SERIALIZER_MSB_FIRST_EN
   assign out_data   = shreg_q[IN_WIDTH-1 -: OUT_WIDTH];
`else
   assign out_data   = shreg_q[OUT_WIDTH-1:0];
`endif

   assign w_out_fire = out_valid & out_ready;
   // Accepting a new word while the last beat leaves keeps the output stream
   // gap-free; this makes in_ready depend combinationally on out_ready.
   assign in_ready   = ~reset & ((state_q == S_IDLE) | (w_out_fire & out_last_q));
   assign w_in_fire  = in_valid & in_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      out_last_d = out_last_q;
      case (state_q)
         S_IDLE: begin
            if (w_in_fire) begin
               state_d    = S_SEND;
               shreg_d    = in_data;
               cnt_d      = '0;
               out_last_d = C_SINGLE;
            end
         end
         S_SEND: begin
            if (w_out_fire) begin
               if (!out_last_q) begin
                  shreg_d    = w_shreg_shift;
                  cnt_d      = cnt_q + 1'b1;
                  // Registered out_last tracks the counter one beat ahead.
                  out_last_d = ((cnt_q + 1'b1) == C_LAST);
               end else if (w_in_fire) begin
                  shreg_d    = in_data;
                  cnt_d      = '0;
                  out_last_d = C_SINGLE;
               end else begin
                  state_d    = S_IDLE;
                  cnt_d      = '0;
                  out_last_d = 1'b0;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            out_last_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         out_last_q <= out_last_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ready_valid_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ready_valid_serializer                                  |
// | Description : Self-checking bench for ready_valid_serializer: a 32->8    |
// |               instance driven through a scoreboard, plus an 8->8         |
// |               single-beat instance. Honours                              |
// |               READY_VALID_SERIALIZER_MSB_FIRST_EN for beat order.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ready_valid_serializer;

   localparam int NB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_last, out_ready;
   logic [31:0] in_data;
   logic [7:0]  out_data;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_ready;
   logic [7:0]  b_in_data, b_out_data;

   logic [8:0]  sb[$];
   logic [7:0]  sb1[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   ready_valid_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready)
   );

   ready_valid_serializer #(.IN_WIDTH(8), .OUT_WIDTH(8)) u_dut_b1 (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
      .out_ready(b_out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] beat_of(input logic [31:0] w, input int k);
`ifdef READY_VALID_SERIALIZER_MSB_FIRST_EN
      return w[(NB-1-k)*8 +: 8];
`else
      return w[k*8 +: 8];
`endif
   endfunction

   // One cycle: drive at the falling edge, let in_ready settle, then record
   // the handshakes that the next rising edge will perform.
   task automatic step(input logic iv, input logic [31:0] id, input logic ordy);
      logic [8:0] e;
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("beat_without_word", {31'd0, out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("beat", {23'd0, out_last, out_data}, {23'd0, e});
         end
      end
      if (in_valid && in_ready) begin
         for (int k = 0; k < NB; k++) begin
            sb.push_back({(k == NB - 1), beat_of(id, k)});
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Single word, full rate
      step(1'b1, 32'hDDCCBBAA, 1'b1);
      for (int i = 0; i < NB; i++) begin
         step(1'b0, 32'h0, 1'b1);
         chk("w1_out_valid", {31'd0, out_valid}, 32'd1);
         chk("w1_in_ready", {31'd0, in_ready}, (i == NB - 1) ? 32'd1 : 32'd0);
      end
      step(1'b0, 32'h0, 1'b1);
      chk("w1_idle_valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back words, second accepted on the last beat of the first
      step(1'b1, 32'h03020100, 1'b1);
      for (int i = 0; i < 2 * NB; i++) begin
         step(i == NB - 1, 32'h07060504, 1'b1);
         chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
         if (i == NB - 1) chk("b2b_in_fire", {31'd0, in_ready}, 32'd1);
      end
      step(1'b0, 32'h0, 1'b1);
      chk("b2b_idle_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure at beat 1
      step(1'b1, 32'h44332211, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h0, 1'b0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_out_data", {24'd0, out_data}, {24'd0, beat_of(32'h44332211, 1)});
         chk("bp_out_last", {31'd0, out_last}, 32'd0);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset while beat 2 is on the output
      step(1'b1, 32'h88776655, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0);
      chk("pre_rst_data", {24'd0, out_data}, {24'd0, beat_of(32'h88776655, 2)});
      #1 reset = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out_data",  {24'd0, out_data},  32'd0);
      chk("arst_out_last",  {31'd0, out_last},  32'd0);
      chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1);
         chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
      end

      // Random traffic with random backpressure, then drain
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1);
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);

      // Single-beat instance: one word per cycle, every beat last
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         b_in_valid  = (i < 6);
         b_in_data   = 8'(8'h10 + i);
         b_out_ready = 1'b1;
         #1;
         if (i >= 1 && i < 7) chk("b1_out_valid", {31'd0, b_out_valid}, 32'd1);
         if (i < 6) chk("b1_in_ready", {31'd0, b_in_ready}, 32'd1);
         if (b_out_valid && b_out_ready) begin
            chk("b1_out_last", {31'd0, b_out_last}, 32'd1);
            if (sb1.size() == 0) chk("b1_beat_without_word", {31'd0, b_out_valid}, 32'd0);
            else chk("b1_beat", {24'd0, b_out_data}, {24'd0, sb1.pop_front()});
         end
         if (b_in_valid && b_in_ready) sb1.push_back(b_in_data);
      end
      chk("b1_sb_empty", 32'(sb1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
